// File: rtl/ripple_count_capture_pkg.sv
// Shared widths and snapshot FSM encoding for the ripple counter capture block.
package ripple_count_capture_pkg;

    localparam int DEF_IN_W       = 3;
    localparam int DEF_EXT_W      = 8;
    localparam int DEF_STABLE_CYC = 2;

    typedef logic snap_state_t;

    localparam snap_state_t ST_IDLE = 1'b0;
    localparam snap_state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/sync_stable_filter.sv
// Two-flop synchronizer for the asynchronous ripple bus followed by a
// stability filter that strobes once when a value has held long enough.
module sync_stable_filter #(
    parameter int IN_W       = 3,
    parameter int STABLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] cnt_in,
    output logic [IN_W-1:0] value,
    output logic            accept
);

    localparam int RUN_W = $clog2(STABLE_CYC + 2);
    localparam logic [RUN_W-1:0] RUN_ACCEPT = RUN_W'(STABLE_CYC);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(STABLE_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

    logic [IN_W-1:0]  s1_reg;
    logic [IN_W-1:0]  s2_reg;
    logic             vld1_reg;
    logic             vld2_reg;
    logic [RUN_W-1:0] run_reg;
    logic [RUN_W-1:0] run_next;

    // run_reg is the number of consecutive samples s2 has held its value;
    // the vld flags keep reset contents of the chain from counting as samples.
    always_comb begin
        run_next = run_reg;
        if (!vld1_reg) begin
            run_next = '0;
        end else if (vld2_reg && (s1_reg == s2_reg)) begin
            if (run_reg != RUN_MAX) begin
                run_next = run_reg + 1'b1;
            end
        end else begin
            run_next = RUN_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            vld1_reg <= 1'b0;
            vld2_reg <= 1'b0;
            run_reg  <= '0;
        end else begin
            s1_reg   <= cnt_in;
            s2_reg   <= s1_reg;
            vld1_reg <= 1'b1;
            vld2_reg <= vld1_reg;
            run_reg  <= run_next;
        end
    end

    assign value  = s2_reg;
    assign accept = (run_reg == RUN_ACCEPT);

endmodule

// File: rtl/ripple_count_capture.sv
// Extends a filtered ripple-counter value into a wide wrap-tracked total and
// offers a valid/ready snapshot of that total.
module ripple_count_capture
    import ripple_count_capture_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int EXT_W      = DEF_EXT_W,
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  cnt_in,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [EXT_W-1:0] snap_data,
    output logic [EXT_W-1:0] count_ext,
    output logic             wrap_pulse,
    output logic             err_skip
);

    localparam logic [IN_W-1:0] DELTA_ONE = IN_W'(1);

    logic [IN_W-1:0]  f_value;
    logic             f_accept;

    logic [IN_W-1:0]  acc_reg;
    logic             first_reg;
    logic [EXT_W-1:0] count_reg;
    logic             err_reg;
    logic             wrap_reg;
    logic [EXT_W-1:0] snap_data_reg;
    snap_state_t      state_reg;
    snap_state_t      state_next;

    logic [IN_W-1:0]  delta;
    logic [EXT_W-1:0] delta_ext;
    logic             step_en;
    logic             capture;

    sync_stable_filter #(
        .IN_W       (IN_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (cnt_in),
        .value  (f_value),
        .accept (f_accept)
    );

    // Modular difference at counter width recovers the step across a 7->0 wrap.
    assign delta     = f_value - acc_reg;
    assign delta_ext = {{(EXT_W - IN_W){1'b0}}, delta};
    assign step_en   = f_accept && !first_reg && (delta != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg   <= '0;
            first_reg <= 1'b1;
            count_reg <= '0;
            err_reg   <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            wrap_reg <= step_en && (delta == DELTA_ONE) && (f_value == '0);
            if (f_accept) begin
                acc_reg   <= f_value;
                first_reg <= 1'b0;
            end
            if (clr) begin
                count_reg <= '0;
                err_reg   <= 1'b0;
            end else if (step_en) begin
                count_reg <= count_reg + delta_ext;
                if (delta > DELTA_ONE) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE) begin
            if (snap_req) begin
                state_next = ST_HOLD;
            end
        end else begin
            if (snap_ready) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        snap_valid = (state_reg == ST_HOLD);
        capture    = (state_reg == ST_IDLE) && snap_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_data_reg <= '0;
        end else if (capture) begin
            snap_data_reg <= count_reg;
        end
    end

    assign snap_data  = snap_data_reg;
    assign count_ext  = count_reg;
    assign wrap_pulse = wrap_reg;
    assign err_skip   = err_reg;

endmodule
